// File: rtl/rr_mux_arbiter_if.sv
// Bundle of request/data/handshake signals around the shared 4:1 mux arbiter.
// Macro RR_MUX_ARBITER_LOCK_EN adds the lock input for burst ownership.
interface rr_mux_arbiter_if #(
  parameter int W = 8
);
  logic [3:0]     req;
  logic [4*W-1:0] din;
  logic [1:0]     sel;
  logic [3:0]     gnt;
  logic [3:0]     ack;
  logic [W-1:0]   dout;
  logic           out_valid;
  logic           out_ready;
`ifdef RR_MUX_ARBITER_LOCK_EN
  logic           lock;

  modport master (
    input  req, din, out_ready, lock,
    output sel, gnt, ack, dout, out_valid
  );

  modport slave (
    output req, din, out_ready, lock,
    input  sel, gnt, ack, dout, out_valid
  );
`else
  modport master (
    input  req, din, out_ready,
    output sel, gnt, ack, dout, out_valid
  );

  modport slave (
    output req, din, out_ready,
    input  sel, gnt, ack, dout, out_valid
  );
`endif
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux, registered output with valid/ready.
// Macro RR_MUX_ARBITER_LOCK_EN: lock re-grants the acked requester ahead of round-robin.
//
// state  | meaning
// S_IDLE | no word held; arbitrate over req every cycle
// S_SEND | word held in dout for the granted requester, waiting for out_ready
module rr_mux_arbiter #(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  rr_mux_arbiter_if.master  bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t       r_state, w_state_n;
  logic [1:0]   r_last,  w_last_n;
  logic [1:0]   r_sel,   w_sel_n;
  logic [3:0]   r_gnt,   w_gnt_n;
  logic [W-1:0] r_dout,  w_dout_n;
  logic         r_valid, w_valid_n;

  logic         w_hs;
  logic [1:0]   w_base;
  logic [3:0]   w_cand;
  logic         w_keep;
  logic         w_found;
  logic [1:0]   w_win;
  logic [1:0]   w_idx;

  assign w_hs = (r_state == S_SEND) && bus.out_ready;

  // On a handshake the acked winner becomes the new base and is masked out.
  always_comb begin
    w_base  = r_last;
    w_cand  = bus.req;
    w_keep  = 1'b0;
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = r_last;
    if (w_hs) begin
      w_base = r_sel;
      w_cand = bus.req & ~r_gnt;
`ifdef RR_MUX_ARBITER_LOCK_EN
      w_keep = bus.lock && ((bus.req & r_gnt) != 4'b0000);
`endif
    end
    for (int i = 1; i <= 4; i++) begin
      w_idx = w_base + 2'(i);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    if (w_keep) begin
      w_found = 1'b1;
      w_win   = r_sel;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_last_n  = r_last;
    w_sel_n   = r_sel;
    w_gnt_n   = r_gnt;
    w_dout_n  = r_dout;
    w_valid_n = r_valid;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_n = S_SEND;
          w_sel_n   = w_win;
          w_gnt_n   = 4'b0001 << w_win;
          w_dout_n  = bus.din[w_win*W +: W];
          w_valid_n = 1'b1;
        end
      end
      S_SEND: begin
        if (bus.out_ready) begin
          w_last_n = r_sel;
          if (w_found) begin
            w_sel_n   = w_win;
            w_gnt_n   = 4'b0001 << w_win;
            w_dout_n  = bus.din[w_win*W +: W];
          end else begin
            w_state_n = S_IDLE;
            w_gnt_n   = 4'b0000;
            w_valid_n = 1'b0;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= 2'd3;
      r_sel   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_last  <= w_last_n;
      r_sel   <= w_sel_n;
      r_gnt   <= w_gnt_n;
      r_dout  <= w_dout_n;
      r_valid <= w_valid_n;
    end
  end

  assign bus.sel       = r_sel;
  assign bus.gnt       = r_gnt;
  assign bus.dout      = r_dout;
  assign bus.out_valid = r_valid;
  assign bus.ack       = w_hs ? r_gnt : 4'b0000;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus randomized traffic
// against a queue-free behavioural model of the round-robin rules.
module tb_rr_mux_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  rr_mux_arbiter_if #(.W(8)) bus ();

  rr_mux_arbiter #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 4'b0000;
    bus.out_ready = 1'b0;
`ifdef RR_MUX_ARBITER_LOCK_EN
    bus.lock = 1'b0;
`endif
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.gnt !== 4'b0 || bus.ack !== 4'b0 ||
        bus.sel !== 2'd0 || bus.dout !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b g=%b a=%b s=%0d d=%h want all zero",
               bus.out_valid, bus.gnt, bus.ack, bus.sel, bus.dout);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0100;
    bus.din = 32'h00A5_0000;
    bus.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0) begin
      n_err++;
      $display("FAIL single_idle: got v=%b a=%b want v=0 a=0000", bus.out_valid, bus.ack);
    end
    tick();
    n_cmp++;
    if (bus.sel !== 2'd2 || bus.gnt !== 4'b0100 || bus.dout !== 8'hA5 ||
        bus.out_valid !== 1'b1 || bus.ack !== 4'b0100) begin
      n_err++;
      $display("FAIL single_grant: got s=%0d g=%b d=%h v=%b a=%b want s=2 g=0100 d=a5 v=1 a=0100",
               bus.sel, bus.gnt, bus.dout, bus.out_valid, bus.ack);
    end
    bus.req = 4'b0000;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.gnt !== 4'b0 || bus.sel !== 2'd2 || bus.dout !== 8'hA5) begin
      n_err++;
      $display("FAIL single_idle_after: got v=%b g=%b s=%0d d=%h want v=0 g=0000 s=2 d=a5",
               bus.out_valid, bus.gnt, bus.sel, bus.dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h10; exp_d[1] = 8'h21; exp_d[2] = 8'h32; exp_d[3] = 8'h43;
    do_reset();
    bus.req = 4'b1111;
    bus.din = 32'h4332_2110;
    bus.out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.dout !== exp_d[i] || bus.gnt !== 4'(1 << i) || bus.ack !== 4'(1 << i) ||
          bus.sel !== 2'(i) || bus.out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_word%0d: got d=%h g=%b a=%b s=%0d v=%b want d=%h g=%b",
                 i, bus.dout, bus.gnt, bus.ack, bus.sel, bus.out_valid, exp_d[i], 4'(1 << i));
      end
      bus.req[i] = 1'b0;
      tick();
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.gnt !== 4'b0) begin
      n_err++;
      $display("FAIL b2b_idle: got v=%b g=%b want v=0 g=0000", bus.out_valid, bus.gnt);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    bus.req = 4'b1111;
    bus.din = 32'h0403_0201;
    bus.out_ready = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (bus.gnt !== 4'(1 << (k % 4)) || bus.ack !== 4'(1 << (k % 4))) begin
        n_err++;
        $display("FAIL rotation_%0d: got g=%b a=%b want %b", k, bus.gnt, bus.ack, 4'(1 << (k % 4)));
      end
      if (k == 5) bus.req = 4'b0000;
      tick();
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rotation_idle: got v=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.req = 4'b0010;
    bus.din = 32'h0000_5500;
    bus.out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.din = 32'h0000_6600;
        bus.req = 4'b1011;
      end
      #1;
      n_cmp++;
      if (bus.dout !== 8'h55 || bus.gnt !== 4'b0010 || bus.ack !== 4'b0 || bus.out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold%0d: got d=%h g=%b a=%b v=%b want d=55 g=0010 a=0000 v=1",
                 i, bus.dout, bus.gnt, bus.ack, bus.out_valid);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.ack !== 4'b0010 || bus.dout !== 8'h55) begin
      n_err++;
      $display("FAIL stall_ack: got a=%b d=%h want a=0010 d=55", bus.ack, bus.dout);
    end
    bus.req = 4'b1001;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b1000 || bus.ack !== 4'b1000) begin
      n_err++;
      $display("FAIL stall_next: got g=%b a=%b want 1000", bus.gnt, bus.ack);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req = 4'b0011;
    bus.din = 32'h0000_BBAA;
    bus.out_ready = 1'b0;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0001 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre: got g=%b v=%b want g=0001 v=1", bus.gnt, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.gnt !== 4'b0 || bus.ack !== 4'b0 || bus.dout !== 8'h00) begin
      n_err++;
      $display("FAIL rstmid_async: got v=%b g=%b a=%b d=%h want all zero",
               bus.out_valid, bus.gnt, bus.ack, bus.dout);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0 || bus.dout !== 8'hAA) begin
      n_err++;
      $display("FAIL rstmid_regrant: got g=%b s=%0d d=%h want g=0001 s=0 d=aa",
               bus.gnt, bus.sel, bus.dout);
    end
  endtask

`ifdef RR_MUX_ARBITER_LOCK_EN
  task automatic test_lock();
    do_reset();
    bus.req = 4'b0011;
    bus.din = 32'h0000_2211;
    bus.out_ready = 1'b1;
    bus.lock = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (bus.gnt !== 4'b0001 || bus.ack !== 4'b0001) begin
        n_err++;
        $display("FAIL lock_burst%0d: got g=%b a=%b want 0001", i, bus.gnt, bus.ack);
      end
      if (i == 1) bus.lock = 1'b0;
      tick();
    end
    n_cmp++;
    if (bus.gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL lock_release: got g=%b want 0010", bus.gnt);
    end
    do_reset();
    bus.req = 4'b0011;
    bus.out_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL nolock_first: got g=%b want 0001", bus.gnt);
    end
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL nolock_second: got g=%b want 0010", bus.gnt);
    end
  endtask
`endif

  // Random producers: each holds req and its data until acked, then may re-request.
  task automatic test_random();
    logic [3:0] pend;
    logic [7:0] pdat [4];
    bit         mv;
    int         ms, ml, win;
    logic [7:0] md;
    logic [3:0] eg, ea, cand;
    do_reset();
    pend = 4'b0000;
    mv = 1'b0; ms = 0; ml = 3; md = 8'h00;
    for (int k = 0; k < 4; k++) pdat[k] = 8'h00;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          pdat[k] = 8'($urandom);
        end
        bus.din[k*8 +: 8] = pend[k] ? pdat[k] : 8'($urandom);
      end
      bus.req = pend;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      eg = mv ? 4'(1 << ms) : 4'b0000;
      ea = (mv && bus.out_ready) ? eg : 4'b0000;
      n_cmp++;
      if (bus.out_valid !== mv || bus.gnt !== eg || bus.ack !== ea ||
          bus.sel !== 2'(ms) || bus.dout !== md) begin
        n_err++;
        $display("FAIL random_c%0d: got v=%b g=%b a=%b s=%0d d=%h want v=%b g=%b a=%b s=%0d d=%h",
                 c, bus.out_valid, bus.gnt, bus.ack, bus.sel, bus.dout, mv, eg, ea, ms, md);
      end
      if (!mv || bus.out_ready) begin
        if (mv) begin
          ml = ms;
          pend[ms] = 1'b0;
          cand = bus.req & ~eg;
        end else begin
          cand = bus.req;
        end
        win = -1;
        for (int o = 1; o <= 4; o++)
          if (win < 0 && cand[(ml + o) % 4]) win = (ml + o) % 4;
        if (win >= 0) begin
          mv = 1'b1;
          ms = win;
          md = bus.din[win*8 +: 8];
        end else begin
          mv = 1'b0;
        end
      end
      tick();
    end
    bus.req = 4'b0000;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req = 4'b0000;
    bus.din = '0;
    bus.out_ready = 1'b0;
`ifdef RR_MUX_ARBITER_LOCK_EN
    bus.lock = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_rotation();
    test_stall();
    test_reset_mid();
`ifdef RR_MUX_ARBITER_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
